// File: rtl/iwram_pkg.sv
// Shared types and lane helpers for the internal work RAM controllers.
package iwram_pkg;

  localparam int IWRAM_ADDR_W = 14;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} size_e;
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} rmw_state_e;

  // Reserved size behaves as a full word.
  function automatic logic is_word(size_e size);
    return (size == SZ_WORD) || (size == SZ_RSVD);
  endfunction

  function automatic logic [31:0] lane_extract(logic [31:0] word, size_e size, logic [1:0] addr_lo);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {24'h0, word[{addr_lo, 3'b000} +: 8]};
      SZ_HALF: r = {16'h0, word[{addr_lo[1], 4'b0000} +: 16]};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_merge(logic [31:0] old_w, logic [31:0] new_w, size_e size,
                                             logic [1:0] addr_lo);
    logic [31:0] r;
    r = old_w;
    case (size)
      SZ_BYTE: r[{addr_lo, 3'b000} +: 8]     = new_w[7:0];
      SZ_HALF: r[{addr_lo[1], 4'b0000} +: 16] = new_w[15:0];
      default: r = new_w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/iwram_lane_merge.sv
// Combinational lane extract/merge for 32-bit RAM words.
// IWRAM_RMW_ROT_EN enables ARM7-style rotated misaligned reads.
module iwram_lane_merge
  import iwram_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] rd_lane,
  output logic [31:0] merged
);

  size_e sz;
  assign sz = size_e'(size);

`ifdef IWRAM_RMW_ROT_EN
  logic [63:0] dbl;
  always_comb begin
    merged  = lane_merge(rdata, wdata, sz, addr_lo);
    rd_lane = lane_extract(rdata, sz, addr_lo);
    dbl     = {rdata, rdata} >> {addr_lo, 3'b000};
    if (is_word(sz))
      rd_lane = dbl[31:0];
    else if (sz == SZ_HALF && addr_lo[0])
      rd_lane = {rd_lane[7:0], 16'h0, rd_lane[15:8]};
  end
`else
  always_comb begin
    merged  = lane_merge(rdata, wdata, sz, addr_lo);
    rd_lane = lane_extract(rdata, sz, addr_lo);
  end
`endif

endmodule

// File: rtl/iwram_rmw_ctrl.sv
// Bus-side controller for IWRAM port A; sub-word writes are done as read-modify-write.
// Optional rotated misaligned reads via IWRAM_RMW_ROT_EN (see iwram_lane_merge).
module iwram_rmw_ctrl
  import iwram_pkg::*;
#(
  parameter int          ADDR_W      = IWRAM_ADDR_W,
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  rmw_state_e        state_q, state_d;
  logic              we_q, we_d;
  size_e             size_q, size_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              req_ready_q, req_ready_d;
  logic [31:0]       rd_lane, merged;

  iwram_lane_merge u_lane (
    .rdata   (ram_rdata),
    .wdata   (wdata_q),
    .size    (size_q),
    .addr_lo (addr_lo_q),
    .rd_lane (rd_lane),
    .merged  (merged)
  );

  // All outputs are registered: ram_addr/ram_we are set up on the edge entering the state that uses them.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    addr_lo_d   = addr_lo_q;
    wdata_d     = wdata_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    req_ready_d = req_ready_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d        = req_we;
        size_d      = size_e'(req_size);
        addr_lo_d   = req_addr[1:0];
        wdata_d     = req_wdata;
        ram_addr_d  = req_addr[ADDR_W+1:2];
        if (req_we && is_word(size_e'(req_size))) begin
          ram_we_d    = 1'b1;
          ram_wdata_d = req_wdata;
        end
        req_ready_d = 1'b0;
        state_d     = ACCESS;
      end
      ACCESS: begin
        if (!we_q || is_word(size_q)) begin
          if (!we_q) rsp_rdata_d = rd_lane;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          ram_we_d    = 1'b1;
          ram_wdata_d = merged;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      addr_lo_q   <= 2'b00;
      wdata_q     <= 32'h0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= RESET_RDATA;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      addr_lo_q   <= addr_lo_d;
      wdata_q     <= wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule
